// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN layer blocks: output-map sizing and safe counter widths.
package cnn_pkg;

    function automatic int out_dim(input int size, input int k, input int stride);
        return (size - k) / stride + 1;
    endfunction

    // Width of a counter over 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Per-column shift register holding the DEPTH most recent rows of the image.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH        = 28,
    parameter int DEPTH        = 2,
    parameter int NUM_CHANNELS = 1,
    parameter int VALUE_BITS   = 16
) (
    input  logic                                                clock_i,
    input  logic                                                write_en_i,
    input  logic [clog2_min1(WIDTH)-1:0]                        col_i,
    input  logic [NUM_CHANNELS-1:0][VALUE_BITS-1:0]             pixel_i,
    output logic [DEPTH-1:0][NUM_CHANNELS-1:0][VALUE_BITS-1:0]  column_o
);

    // Row 0 is the oldest stored row; row DEPTH-1 the most recent.
    logic [NUM_CHANNELS-1:0][VALUE_BITS-1:0] mem [WIDTH][DEPTH];

    always_comb begin
        column_o = '0;
        for (int d = 0; d < DEPTH; d++) begin
            column_o[d] = mem[col_i][d];
        end
    end

    always_ff @(posedge clock_i) begin
        if (write_en_i) begin
            for (int d = 0; d < DEPTH - 1; d++) begin
                mem[col_i][d] <= mem[col_i][d + 1];
            end
            mem[col_i][DEPTH - 1] <= pixel_i;
        end
    end

endmodule

// File: rtl/sliding_window_buffer.sv
// Streaming KxK window generator: raster pixels in, strided unpadded windows out
// through a single-entry valid/ready output register.
module sliding_window_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH        = 28,
    parameter int HEIGHT       = 28,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int NUM_CHANNELS = 1,
    parameter int VALUE_BITS   = 16
) (
    input  logic                                      clock_i,
    input  logic                                      reset_i,
    input  logic [NUM_CHANNELS-1:0][VALUE_BITS-1:0]   in_pixel_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    output logic [NUM_CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][VALUE_BITS-1:0] out_window_o,
    output logic [clog2_min1(out_dim(HEIGHT, KERNEL_SIZE, STRIDE))-1:0] out_row_o,
    output logic [clog2_min1(out_dim(WIDTH, KERNEL_SIZE, STRIDE))-1:0]  out_col_o,
    output logic                                      out_last_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i
);

    localparam int K     = KERNEL_SIZE;
    localparam int OUT_W = out_dim(WIDTH, K, STRIDE);
    localparam int OUT_H = out_dim(HEIGHT, K, STRIDE);
    localparam int RW    = clog2_min1(OUT_H);
    localparam int CW    = clog2_min1(OUT_W);
    localparam int RB    = clog2_min1(HEIGHT);
    localparam int CB    = clog2_min1(WIDTH);
    localparam int PB    = clog2_min1(STRIDE);
    localparam int LB_D  = (K > 1) ? K - 1 : 1;

    logic [RB-1:0] r;
    logic [CB-1:0] c;
    logic [PB-1:0] rph;
    logic [PB-1:0] cph;
    logic [RW-1:0] orow;
    logic [CW-1:0] ocol;
    logic          accept;
    logic          complete;
    logic          row_end;
    logic          frame_end;

    logic [LB_D-1:0][NUM_CHANNELS-1:0][VALUE_BITS-1:0]             lb_col;
    logic [NUM_CHANNELS-1:0][K-1:0][K-1:0][VALUE_BITS-1:0]         win;
    logic [NUM_CHANNELS-1:0][K-1:0][K-1:0][VALUE_BITS-1:0]         next_win;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign row_end    = (int'(c) == WIDTH - 1);
    assign frame_end  = row_end && (int'(r) == HEIGHT - 1);
    assign complete   = accept && (int'(r) >= K - 1) && (int'(c) >= K - 1)
                        && (rph == '0) && (cph == '0);

    generate
        if (K > 1) begin : g_lines
            line_buffer #(
                .WIDTH        (WIDTH),
                .DEPTH        (K - 1),
                .NUM_CHANNELS (NUM_CHANNELS),
                .VALUE_BITS   (VALUE_BITS)
            ) u_line_buffer (
                .clock_i    (clock_i),
                .write_en_i (accept),
                .col_i      (c),
                .pixel_i    (in_pixel_i),
                .column_o   (lb_col)
            );
        end else begin : g_no_lines
            assign lb_col = '0;
        end
    endgenerate

    // New rightmost column: stored rows oldest first, then the incoming pixel.
    always_comb begin
        next_win = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++) begin
                    next_win[ch][ky][kx] = win[ch][ky][kx + 1];
                end
                next_win[ch][ky][K - 1] = (ky < K - 1) ? lb_col[ky][ch] : in_pixel_i[ch];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            win <= next_win;
        end
    end

    // Position and stride-phase counters track the next pixel to accept.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r   <= '0;
            c   <= '0;
            rph <= '0;
            cph <= '0;
        end else if (accept) begin
            if (row_end) begin
                c   <= '0;
                cph <= '0;
                if (frame_end) begin
                    r   <= '0;
                    rph <= '0;
                end else begin
                    r   <= r + 1'b1;
                    rph <= (int'(r) < K - 1 || int'(rph) == STRIDE - 1) ? '0 : rph + 1'b1;
                end
            end else begin
                c   <= c + 1'b1;
                cph <= (int'(c) < K - 1 || int'(cph) == STRIDE - 1) ? '0 : cph + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            orow         <= '0;
            ocol         <= '0;
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            out_row_o    <= '0;
            out_col_o    <= '0;
            out_window_o <= '0;
        end else if (complete) begin
            out_valid_o  <= 1'b1;
            out_window_o <= next_win;
            out_row_o    <= orow;
            out_col_o    <= ocol;
            out_last_o   <= (int'(orow) == OUT_H - 1) && (int'(ocol) == OUT_W - 1);
            if (int'(ocol) == OUT_W - 1) begin
                ocol <= '0;
                orow <= (int'(orow) == OUT_H - 1) ? '0 : orow + 1'b1;
            end else begin
                ocol <= ocol + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
